// File: rtl/ft_nmr_module.sv
// ft_nmr_module: N-modular lockstep write comparator with shadow register file and rollback recovery
module ft_nmr_module #(
    parameter int NUM_CORES  = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic [NUM_CORES-1:0]             we_i,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  data_i,
    input  logic [DATA_WIDTH-1:0]            spc_i,
    input  logic                             halted_i,
    output logic [DATA_WIDTH-1:0]            spc_o,
    output logic                             halt_o,
    output logic                             reset_o,
    output logic                             resume_o,
    output logic                             replay_we_o,
    output logic [ADDR_WIDTH-1:0]            replay_addr_o,
    output logic [DATA_WIDTH-1:0]            replay_data_o,
    output logic [NUM_CORES-1:0]             fault_o,
    output logic [CNT_WIDTH-1:0]             err_cnt_o,
    output logic                             fatal_o
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic TMR = (NUM_CORES == 3);

    typedef enum logic [2:0] {IDLE, HALT, RESET, REPLAY, RESUME, FATAL} state_t;

    state_t                  state;
    logic [RW-1:0]           retry;
    logic [DATA_WIDTH-1:0]   shadow [NUM_REGS];
    logic                    we_a   [3];
    logic [ADDR_WIDTH-1:0]   addr_a [3];
    logic [DATA_WIDTH-1:0]   data_a [3];
    logic                    m01, m02, m12, all_eq, corr, uncorr, active, commit, sel, c_we;
    logic [2:0]              odd;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_data;

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_core
            if (k < NUM_CORES) begin : g_in
                assign we_a[k]   = we_i[k];
                assign addr_a[k] = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                assign data_a[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign we_a[k]   = we_i[0];
                assign addr_a[k] = addr_i[0 +: ADDR_WIDTH];
                assign data_a[k] = data_i[0 +: DATA_WIDTH];
            end
        end
    endgenerate

    function automatic logic same(input logic wa, input logic wb,
                                  input logic [ADDR_WIDTH-1:0] aa, input logic [ADDR_WIDTH-1:0] ab,
                                  input logic [DATA_WIDTH-1:0] da, input logic [DATA_WIDTH-1:0] db);
        return (!wa && !wb) || (wa && wb && aa == ab && da == db);
    endfunction

    always_comb begin
        m01     = same(we_a[0], we_a[1], addr_a[0], addr_a[1], data_a[0], data_a[1]);
        m02     = same(we_a[0], we_a[2], addr_a[0], addr_a[2], data_a[0], data_a[2]);
        m12     = same(we_a[1], we_a[2], addr_a[1], addr_a[2], data_a[1], data_a[2]);
        all_eq  = TMR ? (m01 && m12) : m01;
        odd     = TMR ? {m01 && !m12, m02 && !m01, m12 && !m01} : 3'b000;
        corr    = |odd;
        uncorr  = !all_eq && !corr;
        sel     = odd[0];
        c_we    = sel ? we_a[1] : we_a[0];
        c_addr  = sel ? addr_a[1] : addr_a[0];
        c_data  = sel ? data_a[1] : data_a[0];
        active  = (state == IDLE) && enable_i;
        commit  = active && !uncorr && c_we;
    end

    assign replay_data_o = shadow[replay_addr_o];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            retry         <= '0;
            spc_o         <= '0;
            halt_o        <= 1'b0;
            reset_o       <= 1'b0;
            resume_o      <= 1'b0;
            replay_we_o   <= 1'b0;
            replay_addr_o <= '0;
            fault_o       <= '0;
            err_cnt_o     <= '0;
            fatal_o       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else begin
            if (commit) shadow[c_addr] <= c_data;
            case (state)
                IDLE: if (active) begin
                    if (!all_eq && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                    fault_o <= fault_o | odd[NUM_CORES-1:0];
                    if (commit) retry <= '0;
                    if (uncorr && retry == RW'(MAX_RETRY)) begin
                        state   <= FATAL;
                        fatal_o <= 1'b1;
                        halt_o  <= 1'b1;
                    end else if (uncorr) begin
                        state  <= HALT;
                        halt_o <= 1'b1;
                        retry  <= retry + 1'b1;
                    end else begin
                        spc_o <= spc_i;
                    end
                end
                HALT: if (halted_i) begin
                    state   <= RESET;
                    halt_o  <= 1'b0;
                    reset_o <= 1'b1;
                end
                RESET: begin
                    state         <= REPLAY;
                    reset_o       <= 1'b0;
                    replay_we_o   <= 1'b1;
                    replay_addr_o <= '0;
                end
                REPLAY: begin
                    replay_addr_o <= replay_addr_o + 1'b1;
                    if (replay_addr_o == ADDR_WIDTH'(NUM_REGS - 1)) begin
                        state       <= RESUME;
                        replay_we_o <= 1'b0;
                        resume_o    <= 1'b1;
                    end
                end
                RESUME: begin
                    state    <= IDLE;
                    resume_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
